// File: rtl/pe_array_seq.sv
// pe_array_seq: sequences weight load, row streaming and drain for an N x N PE array.
// Optional PE_SEQ_PERF_CNT_EN adds cyc_cnt/stall_cnt performance counters.
module pe_array_seq #(
  parameter int N      = 8,
  parameter int PE_LAT = 2,
  parameter int AW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          width_cfg,
  input  logic [AW-1:0] num_rows,
  input  logic          src_valid,
  output logic [AW-1:0] w_addr,
  output logic [N-1:0]  weight_en,
  output logic [AW-1:0] x_addr,
  output logic          x_valid,
  output logic          pe_enable,
  output logic          pe_width,
  output logic          res_valid,
  output logic [AW-1:0] res_addr,
  output logic          busy,
`ifdef PE_SEQ_PERF_CNT_EN
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   stall_cnt,
`endif
  output logic          done
);
  localparam int D  = 2*N-1+PE_LAT;
  localparam int CW = $clog2(N);
  localparam int DW = $clog2(D+1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] col;
  logic [AW-1:0] row, rows;
  logic [DW-1:0] dcnt;
  logic [D-1:0] vq;
  logic [AW-1:0] aq [D];
  logic last_col, last_row, last_drain;
  assign last_col   = state == LOAD_W && src_valid && col == CW'(N-1);
  assign last_row   = state == STREAM && src_valid && row == rows - 1'b1;
  assign last_drain = dcnt == DW'(D-1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD_W : IDLE;
      LOAD_W:  nxt = last_col ? (rows == '0 ? DRAIN : STREAM) : LOAD_W;
      STREAM:  nxt = last_row ? DRAIN : STREAM;
      DRAIN:   nxt = last_drain ? FIN : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    weight_en = (state == LOAD_W && src_valid) ? N'(1) << col : '0;
    x_valid   = state == STREAM && src_valid;
    pe_enable = state == STREAM || state == DRAIN;
    busy      = state != IDLE;
    done      = state == FIN;
    w_addr    = AW'(col);
    x_addr    = row;
    res_valid = vq[D-1];
    res_addr  = aq[D-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      rows     <= '0;
      dcnt     <= '0;
      pe_width <= 1'b0;
    end else if (state == IDLE && start) begin
      col      <= '0;
      row      <= '0;
      dcnt     <= '0;
      rows     <= num_rows;
      pe_width <= width_cfg;
    end else begin
      if (state == LOAD_W && src_valid && !last_col) col <= col + 1'b1;
      if (x_valid && !last_row) row <= row + 1'b1;
      if (state == DRAIN) dcnt <= dcnt + 1'b1;
    end
  end
  // Result timing mirrors the array latency; stall bubbles ride along as zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      vq <= '0;
      for (int i = 0; i < D; i++) aq[i] <= '0;
    end else begin
      vq    <= {vq[D-2:0], x_valid};
      aq[0] <= x_addr;
      for (int i = 1; i < D; i++) aq[i] <= aq[i-1];
    end
  end
`ifdef PE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && ~&cyc_cnt) cyc_cnt <= cyc_cnt + 1'b1;
      if ((state == LOAD_W || state == STREAM) && !src_valid && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/pe_array_seq.md
PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 SHALL have parameter N, default 8: PE array dimension (N x N PE16 tiles); legal 2..16.
REQ-002 SHALL have parameter PE_LAT, default 2: per-PE product/accumulate pipeline depth in clk cycles.
REQ-003 SHALL have parameter AW, default 12: buffer address width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  job request pulse; accepted only in IDLE.
REQ-007 width_cfg  in  1  job operand width (1 = 8-bit, 0 = 16-bit); latched at start.
REQ-008 num_rows  in  AW  matrix rows to stream; latched at start; 0 is legal.
REQ-009 src_valid  in  1  weight/matrix buffer data available this cycle.
REQ-010 w_addr  out  AW  weight buffer read address.
REQ-011 weight_en  out  N  one-hot per-column Weight_enable to the array.
REQ-012 x_addr  out  AW  matrix buffer read address.
REQ-013 x_valid  out  1  matrix row presented to array edge this cycle.
REQ-014 pe_enable  out  1  array accumulate enable (drives PE enable).
REQ-015 pe_width  out  1  array width mode (drives PE width).
REQ-016 res_valid  out  1  array output row valid; res_addr  out  AW  result write address.
REQ-017 busy  out  1; done  out  1 (single-cycle pulse).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN, FIN.
REQ-019 IDLE -> LOAD_W on start; latch width_cfg, num_rows; clear w_addr, x_addr, counters.
REQ-020 LOAD_W: each cycle with src_valid=1, assert weight_en bit c (c = load counter), w_addr = c, increment c; with src_valid=0 hold c, weight_en = 0.
REQ-021 LOAD_W -> STREAM after column N-1 loaded; -> DRAIN directly if num_rows = 0.
REQ-022 STREAM: each cycle with src_valid=1, x_valid=1, x_addr = row counter, increment row; src_valid=0 stalls (x_valid=0, counters hold).
REQ-023 STREAM -> DRAIN on cycle issuing row num_rows-1.
REQ-024 DRAIN: count exactly 2*N-1+PE_LAT cycles, independent of src_valid; then -> FIN.
REQ-025 FIN: done=1 for one cycle; -> IDLE next cycle.
REQ-026 pe_enable SHALL be 1 in STREAM and DRAIN, 0 otherwise; pe_width = latched width_cfg while busy, holds last value in IDLE.
REQ-027 res_valid SHALL be x_valid delayed by 2*N-1+PE_LAT cycles (shift register); res_addr = x_addr delayed identically; stall bubbles propagate as res_valid=0.
REQ-028 busy SHALL be 1 in all states except IDLE.
REQ-029 start while not IDLE SHALL be ignored (no queueing).
REQ-030 Counters SHALL not wrap: row counter compares against num_rows before increment; num_rows = 2^AW-1 is legal.
REQ-031 weight_en SHALL never have more than one bit set.

Reset
REQ-032 rst=1 at any clock edge SHALL force IDLE, all outputs 0 (pe_width 0), delay line cleared, regardless of state (mid-job abort, no done).
REQ-033 start coincident with rst SHALL be ignored.

Configuration
REQ-034 Macro PE_SEQ_PERF_CNT_EN defined: adds outputs cyc_cnt (32) counting cycles with busy=1 and stall_cnt (32) counting LOAD_W/STREAM cycles with src_valid=0; both clear at accepted start and on rst, saturate at 2^32-1.
REQ-035 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-036 N=4, PE_LAT=2, num_rows=3, src_valid=1 constant: weight_en 0001,0010,0100,1000 cycles 1-4; x_valid cycles 5-7, x_addr 0,1,2; res_valid 3 cycles starting 9 cycles after first x_valid; done one cycle after DRAIN's 9 cycles.
REQ-037 Same job, src_valid=0 on 2nd STREAM cycle: x_addr 0,-,1,2; res_valid pattern 1,0,1,1; stall_cnt=1 with macro.
REQ-038 num_rows=0: LOAD_W 4 cycles -> DRAIN 9 cycles -> done; x_valid and res_valid never asserted.
REQ-039 rst asserted mid-STREAM (row 1): next cycle IDLE, busy=0, res_valid=0, no done; new start runs clean job.
REQ-040 start pulses during STREAM and on FIN cycle: ignored; width_cfg change mid-job does not alter pe_width.
